// File: rtl/merlin_irq_stim_pkg.sv
// rtl/merlin_irq_stim_pkg.sv - shared types and register map for the interrupt stimulus generator
package merlin_irq_stim_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_PULSE    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PEND  = 2'b10
    } state_e;

    localparam logic [31:0] ACK_OFS    = 32'd0;
    localparam logic [31:0] CFG_OFS    = 32'd4;
    localparam logic [31:0] CFG_STRIDE = 32'd4;

    function automatic logic [31:0] cfg_addr(input logic [31:0] base, input int unsigned n);
        return base + CFG_OFS + CFG_STRIDE * 32'(n);
    endfunction

endpackage

// File: rtl/merlin_irq_stim_if.sv
// rtl/merlin_irq_stim_if.sv - core data request port as seen by the bus snooper
interface merlin_irq_stim_if;
    logic        dreqvalid_i;
    logic        dreqready_i;
    logic        dreqwrite_i;
    logic [31:0] dreqaddr_i;
    logic [31:0] dreqdata_i;

    modport master (
        output dreqvalid_i, dreqready_i, dreqwrite_i, dreqaddr_i, dreqdata_i
    );

    modport slave (
        input dreqvalid_i, dreqready_i, dreqwrite_i, dreqaddr_i, dreqdata_i
    );
endinterface

// File: rtl/merlin_irq_stim_chan.sv
// rtl/merlin_irq_stim_chan.sv - one interrupt channel: mode FSM, period counter and compare
module merlin_irq_stim_chan
    import merlin_irq_stim_pkg::*;
#(
    parameter int unsigned          C_CNT_W    = 16,
    parameter mode_e                RST_MODE   = MODE_OFF,
    parameter logic [C_CNT_W-1:0]   RST_PERIOD = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [C_CNT_W-1:0] cfg_period,
    input  mode_e              cfg_mode,
    input  logic               ack,
    output logic               irq,
    output logic               pend
);

    localparam state_e RST_STATE = (RST_MODE == MODE_OFF) ? ST_IDLE : ST_COUNT;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [C_CNT_W-1:0] period_q, period_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               irq_q, irq_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RST_STATE;
            mode_q   <= RST_MODE;
            period_q <= RST_PERIOD;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
        if (cfg_we) begin
            mode_d   = cfg_mode;
            period_d = cfg_period;
            cnt_d    = '0;
            irq_d    = 1'b0;
            state_d  = (cfg_mode == MODE_OFF) ? ST_IDLE : ST_COUNT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    irq_d = 1'b0;
                end
                ST_COUNT: begin
                    if (mode_q == MODE_PULSE) begin
                        // acks are ignored; the pulse self-clears on the following edge
                        irq_d = (cnt_q == period_q);
                        cnt_d = irq_d ? '0 : cnt_q + 1'b1;
                    end else if (ack) begin
                        cnt_d = '0;
                        irq_d = 1'b0;
                    end else if (cnt_q == period_q) begin
                        irq_d   = 1'b1;
                        state_d = ST_PEND;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PEND: begin
                    if (ack) begin
                        irq_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_PERIODIC) ? ST_COUNT : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            endcase
        end
    end

    assign irq  = irq_q;
    assign pend = (state_q == ST_PEND);

endmodule

// File: rtl/merlin_irq_stim.sv
// rtl/merlin_irq_stim.sv - bus-snooping multi-channel interrupt stimulus generator top
module merlin_irq_stim
    import merlin_irq_stim_pkg::*;
#(
    parameter int unsigned C_NCHAN          = 9,
    parameter int unsigned C_CNT_W          = 16,
    parameter logic [31:0] C_BASE_ADDR      = 32'h0000_0004,
    parameter int unsigned C_DEFAULT_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    merlin_irq_stim_if.slave     dreq,
    output logic [C_NCHAN-1:0]   irq_o,
    output logic [C_NCHAN-1:0]   pend_o
);

    localparam logic [C_CNT_W-1:0] DEF_PERIOD = C_CNT_W'(C_DEFAULT_PERIOD);

    logic               wr_acc;
    logic               ack_hit;
    logic [C_NCHAN-1:0] ack_vec;
    logic [C_CNT_W-1:0] cfg_period;
    mode_e              cfg_mode;
    logic               unused_data;

    // only accepted writes are snooped; the block never answers the request
    assign wr_acc     = dreq.dreqvalid_i & dreq.dreqready_i & dreq.dreqwrite_i;
    assign ack_hit    = wr_acc && (dreq.dreqaddr_i == C_BASE_ADDR + ACK_OFS);
    assign ack_vec    = ack_hit ? dreq.dreqdata_i[C_NCHAN-1:0] : '0;
    assign cfg_period = dreq.dreqdata_i[C_CNT_W-1:0];
    assign cfg_mode   = mode_e'(dreq.dreqdata_i[31:30]);
    assign unused_data = ^dreq.dreqdata_i;

    for (genvar n = 0; n < C_NCHAN; n++) begin : g_chan
        localparam mode_e              RM = (n == 0) ? MODE_PERIODIC : MODE_OFF;
        localparam logic [C_CNT_W-1:0] RP = (n == 0) ? DEF_PERIOD : '0;

        logic cfg_we;
        assign cfg_we = wr_acc && (dreq.dreqaddr_i == cfg_addr(C_BASE_ADDR, n));

        merlin_irq_stim_chan #(
            .C_CNT_W    (C_CNT_W),
            .RST_MODE   (RM),
            .RST_PERIOD (RP)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (cfg_we),
            .cfg_period (cfg_period),
            .cfg_mode   (cfg_mode),
            .ack        (ack_vec[n]),
            .irq        (irq_o[n]),
            .pend       (pend_o[n])
        );
    end

endmodule
